// File: rtl/seg7_scan_if.sv
// Bundles the frame load bus and the display-drive outputs of the 7-segment scanner.
// The controller side (master) supplies frame data; the scanner side (slave) drives the display.
interface seg7_scan_if #(
  parameter int DIGITS = 6
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dash_mask;
  logic [4:0]            hex;
  logic [DIGITS-1:0]     digit_sel;
  logic                  frame_tick;

  modport master (
    output load, value, dash_mask,
    input  hex, digit_sel, frame_tick
  );

  modport slave (
    input  load, value, dash_mask,
    output hex, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed scanner for a common-bus 7-segment display.
// One digit is enabled per scan slot; the first BLANK_CYC cycles of every slot are
// blanked so the bus code can settle without ghosting into the neighbouring digit.
// Frame data is double-buffered: loads land in a pending buffer and are copied to the
// display registers only on the last cycle of a frame, so a frame never mixes old and new.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress the digit select of leading
// zero digits (digit 0 is always shown).
module seg7_scan #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]            pcnt_r;
  logic [IW-1:0]            idx_r;
  logic [DIGITS-1:0][3:0]   disp_val_r;
  logic [DIGITS-1:0]        disp_dash_r;
  logic [DIGITS-1:0][3:0]   pend_val_r;
  logic [DIGITS-1:0]        pend_dash_r;
  logic                     pend_vld_r;

  logic                     pcnt_last_s;
  logic                     idx_last_s;
  logic                     frame_tick_s;
  logic                     blank_s;
  logic                     supp_s;
  logic [4:0]               hex_s;
  logic [DIGITS-1:0]        digit_sel_s;

  assign pcnt_last_s  = (pcnt_r == PW'(SCAN_DIV - 1));
  assign idx_last_s   = (idx_r == IW'(DIGITS - 1));
  assign frame_tick_s = pcnt_last_s && idx_last_s;

  // Anti-ghost window at the start of every slot; a zero-length window never blanks.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank_s = 1'b0;
    end else begin : g_blank
      assign blank_s = (pcnt_r < PW'(BLANK_CYC));
    end
  endgenerate

  // Slot prescaler and digit index; the index steps when the prescaler wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_r <= '0;
      idx_r  <= '0;
    end else if (pcnt_last_s) begin
      pcnt_r <= '0;
      if (idx_last_s) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IW'(1);
      end
    end else begin
      pcnt_r <= pcnt_r + PW'(1);
    end
  end

  // Pending buffer capture and frame-boundary transfer into the display registers.
  // A load on the boundary cycle bypasses the pending buffer so it is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_val_r  <= '0;
      pend_dash_r <= '0;
      pend_vld_r  <= 1'b0;
      disp_val_r  <= '0;
      disp_dash_r <= '0;
    end else begin
      if (bus.load) begin
        pend_val_r  <= bus.value;
        pend_dash_r <= bus.dash_mask;
      end
      if (frame_tick_s) begin
        pend_vld_r <= 1'b0;
        if (bus.load) begin
          disp_val_r  <= bus.value;
          disp_dash_r <= bus.dash_mask;
        end else if (pend_vld_r) begin
          disp_val_r  <= pend_val_r;
          disp_dash_r <= pend_dash_r;
        end
      end else if (bus.load) begin
        pend_vld_r <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_s;
  logic              run_s;

  // Leading-zero detection from the display registers only, so it is stable per frame.
  always_comb begin
    run_s  = 1'b1;
    lead_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_s     = run_s & (disp_val_r[i] == 4'h0) & ~disp_dash_r[i];
      lead_s[i] = run_s;
    end
    if (idx_r != '0) begin
      supp_s = lead_s[idx_r];
    end else begin
      supp_s = 1'b0;
    end
  end
`else
  assign supp_s = 1'b0;
`endif

  // Bus code for the current digit: dash bar overrides the nibble.
  always_comb begin
    hex_s = 5'h00;
    if (disp_dash_r[idx_r]) begin
      hex_s = 5'h10;
    end else begin
      hex_s = {1'b0, disp_val_r[idx_r]};
    end
  end

  // One-hot digit enable, forced off during the blank window or for a suppressed digit.
  always_comb begin
    digit_sel_s = '0;
    if (blank_s || supp_s) begin
      digit_sel_s = '0;
    end else begin
      digit_sel_s = DIGITS'(1) << idx_r;
    end
  end

  assign bus.hex        = hex_s;
  assign bus.digit_sel  = digit_sel_s;
  assign bus.frame_tick = frame_tick_s;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1).
// Stimulus pushes the hand-computed visible cycles of each frame into a queue;
// the monitor pops one entry for every cycle in which a digit is selected.
module tb_seg7_scan;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic mon_en;
  logic [9:0] exp_q[$];   // {frame_tick, digit_sel[3:0], hex[4:0]}

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] VIS_ZERO = 4'b0001;
  localparam logic [3:0] VIS_0070 = 4'b0011;
`else
  localparam logic [3:0] VIS_ZERO = 4'b1111;
  localparam logic [3:0] VIS_0070 = 4'b1111;
`endif

  seg7_scan_if #(.DIGITS(4)) bus ();

  seg7_scan #(
    .DIGITS   (4),
    .SCAN_DIV (4),
    .BLANK_CYC(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare every visible cycle against the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en && (bus.digit_sel != 4'b0000)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scan_unexpected: got sel=%b hex=%h ft=%b, want no visible digit",
                 bus.digit_sel, bus.hex, bus.frame_tick);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({bus.frame_tick, bus.digit_sel, bus.hex} !== e) begin
          errors++;
          $display("FAIL scan: got sel=%b hex=%h ft=%b, want sel=%b hex=%h ft=%b",
                   bus.digit_sel, bus.hex, bus.frame_tick, e[8:5], e[4:0], e[9]);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // codes = {digit3, digit2, digit1, digit0}; each visible digit has 3 visible cycles.
  task automatic push_frame(input logic [19:0] codes, input logic [3:0] vis);
    for (int d = 0; d < 4; d++) begin
      if (vis[d]) begin
        for (int k = 1; k < 4; k++) begin
          logic [3:0] sel;
          sel = 4'b0001 << d;
          exp_q.push_back({(d == 3 && k == 3), sel, codes[5*d +: 5]});
        end
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dm);
    bus.load      = 1'b1;
    bus.value     = v;
    bus.dash_mask = dm;
    tick(1);
    bus.load      = 1'b0;
    bus.value     = 16'h0000;
    bus.dash_mask = 4'b0000;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d entries left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    mon_en        = 1'b0;
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.value     = 16'h0000;
    bus.dash_mask = 4'b0000;

    // Reset held for 3 cycles, then cycle 0 of the first frame.
    tick(3);
    rst_n = 1'b1;
    check("reset_sel", 32'(bus.digit_sel), 32'h0);
    check("reset_hex", 32'(bus.hex), 32'h00);
    check("reset_ft", 32'(bus.frame_tick), 32'h0);

    push_frame({5'h00, 5'h00, 5'h00, 5'h00}, VIS_ZERO);  // frame 0: reset contents
    push_frame({5'h01, 5'h02, 5'h0A, 5'h0F}, 4'b1111);   // frame 1: 12AF
    push_frame({5'h01, 5'h10, 5'h03, 5'h04}, 4'b1111);   // frame 2: 1234, dash on digit 2
    push_frame({5'h05, 5'h05, 5'h05, 5'h05}, 4'b1111);   // frame 3: 5555 via boundary load
    push_frame({5'h02, 5'h02, 5'h02, 5'h02}, 4'b1111);   // frame 4: last of two loads
    mon_en = 1'b1;

    tick(6);                          // cycle 6
    do_load(16'h12AF, 4'b0000);       // -> cycle 7
    tick(7);                          // cycle 14
    check("ft_before_end", 32'(bus.frame_tick), 32'h0);
    tick(1);                          // cycle 15
    check("ft_last_cycle", 32'(bus.frame_tick), 32'h1);
    tick(5);                          // cycle 20
    do_load(16'h1234, 4'b0100);       // -> cycle 21
    tick(26);                         // cycle 47: frame_tick of frame 2
    check("ft_collision", 32'(bus.frame_tick), 32'h1);
    do_load(16'h5555, 4'b0000);       // -> cycle 48
    tick(2);                          // cycle 50
    do_load(16'h1111, 4'b0000);       // -> cycle 51
    tick(4);                          // cycle 55
    do_load(16'h2222, 4'b0000);       // -> cycle 56
    tick(24);                         // cycle 80
    mon_en = 1'b0;
    check_drained("drain_load");

    // Mid-frame reset with a load pending while digit 2 is scanned.
    tick(8);                          // cycle 88: idx 2, slot start
    do_load(16'h9999, 4'b0000);       // -> cycle 89
    check("pre_reset_sel", 32'(bus.digit_sel), 32'h4);
    check("pre_reset_hex", 32'(bus.hex), 32'h02);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;                     // cycle 0 after reset
    check("midreset_sel", 32'(bus.digit_sel), 32'h0);
    check("midreset_hex", 32'(bus.hex), 32'h00);

    push_frame({5'h00, 5'h00, 5'h00, 5'h00}, VIS_ZERO);  // frame 0: cleared display
    push_frame({5'h00, 5'h00, 5'h00, 5'h00}, VIS_ZERO);  // frame 1: pending was dropped
    push_frame({5'h00, 5'h00, 5'h07, 5'h00}, VIS_0070);  // frame 2: 0070
    push_frame({5'h00, 5'h00, 5'h00, 5'h00}, VIS_ZERO);  // frame 3: 0000
    mon_en = 1'b1;

    tick(20);                         // cycle 20
    do_load(16'h0070, 4'b0000);       // -> cycle 21
    tick(19);                         // cycle 40
    do_load(16'h0000, 4'b0000);       // -> cycle 41
    tick(23);                         // cycle 64
    mon_en = 1'b0;
    check_drained("drain_reset_lzb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
